burst_ram_responder: RTL and testbench
======================================

// Module: burst_ram_responder
// PURPOSE
//  Responder end of the burst RAM command interface: accepts read/write commands
//  from the cache and serves 4-beat x 64-bit bursts out of an internal block-RAM array.
//  Stands in for the PSRAM IP in simulation and on boards without PSRAM. Enforces the
//  command interval and flags protocol violations.
// PARAMETERS
//  BURST_RAM_DEPTH_BITWIDTH   21  address width, unit = 8-byte word
//  STORAGE_DEPTH_BITWIDTH     12  implemented array depth 2^N x 64 bit; addr low bits used
//  CYCLES_BEFORE_INITIATED    10  cycles after reset before init_calib rises
//  CYCLES_BEFORE_DATA_VALID    6  edges from cmd_en sample to first read beat (>=2)
//  COMMAND_INTERVAL           14  min edges between accepted commands (>= latency+4)
//  DATA_FILE                  ""  optional $readmemh image; empty = array left unloaded
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  cmd            in   1   0: read, 1: write; valid with cmd_en
//  cmd_en         in   1   command strobe, 1 cycle
//  addr           in   BURST_RAM_DEPTH_BITWIDTH  burst start, 8-byte word address
//  wr_data        in   64  write beat; beat 0 valid with cmd_en
//  data_mask      in   8   accepted, ignored (full 64-bit writes always)
//  rd_data        out  64  read beat
//  rd_data_valid  out  1   rd_data valid; high 4 consecutive cycles per read
//  init_calib     out  1   1 = ready to accept commands
//  busy           out  1   1 = burst active or interval counter != 0
//  protocol_error out  1   sticky: command rejected (see boundary rules)
// BEHAVIOUR
//  Reset: rd_data=0, rd_data_valid=0, init_calib=0, busy=0, protocol_error=0,
//   interval counter=0, state=INIT. Array contents survive reset.
//  States: INIT -> IDLE -> {READ_WAIT -> READ_BURST | WRITE_BURST} -> IDLE.
//  INIT: count CYCLES_BEFORE_INITIATED edges, then init_calib<=1, -> IDLE.
//  Accept: cmd_en && state==IDLE && counter==0. On accept counter<=COMMAND_INTERVAL-1,
//   latch addr & cmd; counter decrements each edge to 0 independent of state.
//  Beat address: beat k (0..3) -> (addr+k) mod 2^STORAGE_DEPTH_BITWIDTH; wraps at array
//   end; upper addr bits above storage width ignored.
//  Write: beat 0 = wr_data at the accept edge, beats 1..3 = wr_data on next 3 edges,
//   each written to array on its edge. WRITE_BURST lasts 3 cycles -> IDLE.
//  Read: READ_WAIT counts; rd_data_valid high exactly on cycles
//   CYCLES_BEFORE_DATA_VALID .. +3 after accept edge, beat k on k-th valid cycle,
//   synchronous array read pre-issued 1 cycle ahead. rd_data holds last beat after.
//  busy = (state!=IDLE && state!=INIT) || counter!=0; 0 in INIT.
//  Read after write: write beats committed before next accepted command; read returns them.
//  Rejects (ignored, protocol_error<=1): cmd_en in INIT; cmd_en while busy (incl. mid
//   burst or interval pending). Rejected command does not disturb active burst.
//  Reset mid-burst: burst aborted, rd_data_valid drops next edge, partial write beats
//   already committed remain; re-enters INIT (init_calib 0 again).
//  Elaboration error if COMMAND_INTERVAL < CYCLES_BEFORE_DATA_VALID+4.
// TESTING
//  Write addr=0x40 beats 0x11..,0x22..,0x33..,0x44.. ; after interval read 0x40 ->
//   4 valid beats in order at cmd+6..+9, rd_data_valid 0 elsewhere.
//  Read at addr=2^12-2 after writes at 0xFFE,0xFFF,0x000,0x001 -> beats wrap to 0x000.
//  cmd_en 5 cycles after accepted read -> ignored, protocol_error=1, read burst intact.
//  cmd_en during INIT (cycle 3 after rst) -> ignored, protocol_error=1, init_calib at 10.
//  rst asserted at 2nd read beat -> rd_data_valid 0 next cycle, init_calib 0, state INIT.
//  Cache + responder closed loop: dirty-line eviction then refill at same line index ->
//   refilled data matches RAM image, evicted data readable at evicted address.

Source files
------------

// File: rtl/burst_ram_responder.sv
// Burst RAM responder: serves 4-beat x 64-bit read/write bursts from an internal
// block-RAM array, enforcing the command interval and flagging rejected commands.
module burst_ram_responder #(
  parameter int    BURST_RAM_DEPTH_BITWIDTH = 21,
  parameter int    STORAGE_DEPTH_BITWIDTH   = 12,
  parameter int    CYCLES_BEFORE_INITIATED  = 10,
  parameter int    CYCLES_BEFORE_DATA_VALID = 6,
  parameter int    COMMAND_INTERVAL         = 14,
  parameter string DATA_FILE                = ""
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd,
  input  logic                                cmd_en,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] addr,
  input  logic [63:0]                         wr_data,
  input  logic [7:0]                          data_mask,
  output logic [63:0]                         rd_data,
  output logic                                rd_data_valid,
  output logic                                init_calib,
  output logic                                busy,
  output logic                                protocol_error
);

  localparam int SW = STORAGE_DEPTH_BITWIDTH;
  localparam int IW = $clog2(COMMAND_INTERVAL + 1);
  localparam int CW = $clog2(CYCLES_BEFORE_DATA_VALID + 5);
  localparam int NW = $clog2(CYCLES_BEFORE_INITIATED + 1);

  localparam logic [IW-1:0] IVL_LOAD = IW'(COMMAND_INTERVAL - 1);
  localparam logic [CW-1:0] C_ISSUE  = CW'(CYCLES_BEFORE_DATA_VALID - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(CYCLES_BEFORE_DATA_VALID + 3);
  localparam logic [NW-1:0] N_DONE   = NW'(CYCLES_BEFORE_INITIATED - 1);

  if (COMMAND_INTERVAL < CYCLES_BEFORE_DATA_VALID + 4) begin : g_bad_interval
    $error("COMMAND_INTERVAL must be >= CYCLES_BEFORE_DATA_VALID + 4");
  end
  if (CYCLES_BEFORE_DATA_VALID < 2) begin : g_bad_latency
    $error("CYCLES_BEFORE_DATA_VALID must be >= 2");
  end

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_READ_WAIT, S_READ_BURST, S_WRITE_BURST
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] init_cnt_q, init_cnt_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [1:0]    wbeat_q, wbeat_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          rvld_q, rvld_d;
  logic          calib_q, calib_d;
  logic          perr_q, perr_d;

  logic          accept;
  logic          mem_we, mem_re;
  logic [SW-1:0] mem_wa;
  logic [63:0]   ram_rd_q;
  logic [63:0]   mem [2**SW];

  // Write mask and address bits above the storage width have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{data_mask, addr};

  assign accept = cmd_en && (state_q == S_IDLE) && (ivl_q == '0);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    calib_d    = calib_q;
    ivl_d      = (ivl_q != '0) ? ivl_q - IW'(1) : ivl_q;
    cyc_d      = cyc_q;
    ptr_d      = ptr_q;
    wbeat_d    = wbeat_q;
    rdata_d    = rdata_q;
    rvld_d     = 1'b0;
    perr_d     = perr_q | (cmd_en & ~accept);
    mem_we     = 1'b0;
    mem_wa     = ptr_q;
    mem_re     = 1'b0;

    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == N_DONE) begin
          calib_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + NW'(1);
        end
      end
      S_IDLE: begin
        if (accept) begin
          ivl_d = IVL_LOAD;
          cyc_d = CW'(1);
          if (cmd) begin
            // Beat 0 lands on the accept edge itself.
            mem_we  = 1'b1;
            mem_wa  = addr[SW-1:0];
            ptr_d   = addr[SW-1:0] + SW'(1);
            wbeat_d = 2'd0;
            state_d = S_WRITE_BURST;
          end else begin
            ptr_d   = addr[SW-1:0];
            state_d = S_READ_WAIT;
          end
        end
      end
      S_READ_WAIT: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == C_ISSUE) begin
          mem_re  = 1'b1;
          ptr_d   = ptr_q + SW'(1);
          state_d = S_READ_BURST;
        end
      end
      S_READ_BURST: begin
        // Array read runs one edge ahead of the output register.
        cyc_d   = cyc_q + CW'(1);
        rvld_d  = 1'b1;
        rdata_d = ram_rd_q;
        if (cyc_q == C_LAST) begin
          state_d = S_IDLE;
        end else begin
          mem_re = 1'b1;
          ptr_d  = ptr_q + SW'(1);
        end
      end
      S_WRITE_BURST: begin
        mem_we  = 1'b1;
        ptr_d   = ptr_q + SW'(1);
        wbeat_d = wbeat_q + 2'd1;
        if (wbeat_q == 2'd2) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      calib_q    <= 1'b0;
      ivl_q      <= '0;
      cyc_q      <= '0;
      ptr_q      <= '0;
      wbeat_q    <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      calib_q    <= calib_d;
      ivl_q      <= ivl_d;
      cyc_q      <= cyc_d;
      ptr_q      <= ptr_d;
      wbeat_q    <= wbeat_d;
      rdata_q    <= rdata_d;
      rvld_q     <= rvld_d;
      perr_q     <= perr_d;
    end
  end

  // Array has no reset so contents survive rst; writes are blocked on the reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_wa] <= wr_data;
    if (mem_re) ram_rd_q <= mem[ptr_q];
  end

  assign rd_data        = rdata_q;
  assign rd_data_valid  = rvld_q;
  assign init_calib     = calib_q;
  assign protocol_error = perr_q;
  assign busy           = ((state_q != S_IDLE) && (state_q != S_INIT)) || (ivl_q != '0);

endmodule

// File: tb/tb_burst_ram_responder.sv
// Bench for burst_ram_responder: table of burst vectors, hand-written corner
// sequences and random traffic, all checked every cycle against a timing/array model.
module tb_burst_ram_responder;

  logic        clk = 1'b0;
  logic        rst, cmd, cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid, init_calib, busy, protocol_error;

  always #5 clk = ~clk;

  burst_ram_responder dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy),
    .protocol_error(protocol_error)
  );

  localparam int DEPTH = 4096;
  localparam int LAT   = 6;
  localparam int IVL   = 14;
  localparam int INITC = 10;

  int n_cmp = 0, n_bad = 0, ecount = 0;

  // Model: array image plus event times, all in edge numbers.
  logic [63:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_ready, m_have_last, m_perr, m_rknown;
  int          m_icnt, m_last, m_wleft, m_wptr;
  logic [63:0] m_rdata;
  logic [63:0] exp_d [int];
  bit          exp_k [int];
  logic [63:0] cap [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic tick();
    int n;
    bit acc, ev;
    int a;
    n = ecount + 1;
    ev = 1'b0;
    if (rst) begin
      m_ready = 0; m_icnt = 0; m_have_last = 0; m_perr = 0; m_wleft = 0;
      m_rdata = '0; m_rknown = 1;
      exp_d.delete(); exp_k.delete();
    end else begin
      acc = 0;
      if (m_wleft > 0) begin
        m_mem[m_wptr] = wr_data; m_known[m_wptr] = 1;
        m_wptr = (m_wptr + 1) % DEPTH; m_wleft--;
      end
      if (cmd_en) begin
        if (m_ready && (!m_have_last || n - m_last >= IVL)) acc = 1;
        else m_perr = 1;
      end
      if (acc) begin
        m_last = n; m_have_last = 1;
        a = int'(addr) % DEPTH;
        if (cmd) begin
          m_mem[a] = wr_data; m_known[a] = 1;
          m_wptr = (a + 1) % DEPTH; m_wleft = 3;
        end else begin
          for (int k = 0; k < 4; k++) begin
            exp_d[n + LAT + k] = m_mem[(a + k) % DEPTH];
            exp_k[n + LAT + k] = m_known[(a + k) % DEPTH];
          end
        end
      end
      if (!m_ready) begin
        m_icnt++;
        if (m_icnt == INITC) m_ready = 1;
      end
      if (exp_d.exists(n)) begin
        ev = 1; m_rdata = exp_d[n]; m_rknown = exp_k[n];
        exp_d.delete(n); exp_k.delete(n);
      end
    end
    @(posedge clk); #1;
    ecount = n;
    chk("rd_data_valid", 64'(rd_data_valid), 64'(ev));
    if (m_rknown) chk("rd_data", rd_data, m_rdata);
    chk("init_calib", 64'(init_calib), 64'(m_ready));
    chk("busy", 64'(busy), 64'(m_have_last && (n - m_last < IVL - 1)));
    chk("protocol_error", 64'(protocol_error), 64'(m_perr));
    if (rd_data_valid) cap.push_back(rd_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_beats(input int want, input string nm);
    int b = 0;
    while (cap.size() < want && b < 40) begin tick(); b++; end
    if (cap.size() < want) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0d beats expected %0d", nm, cap.size(), want);
    end
  endtask

  typedef struct packed {
    logic            wr;
    logic [20:0]     a;
    logic [3:0][63:0] d;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [20:0] a,
                              input logic [63:0] b0, b1, b2, b3);
    vec_t v;
    v.wr = wr; v.a = a; v.d = {b3, b2, b1, b0};
    return v;
  endfunction

  localparam logic [63:0] D1 = 64'h1111111111111111, D2 = 64'h2222222222222222;
  localparam logic [63:0] D3 = 64'h3333333333333333, D4 = 64'h4444444444444444;
  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0FFE, A1 = 64'hA1A1_0000_0000_0FFF;
  localparam logic [63:0] A2 = 64'hA2A2_0000_0000_0000, A3 = 64'hA3A3_0000_0000_0001;
  localparam logic [63:0] B0 = 64'hB0B0_1234_5678_0002, B1 = 64'hB1B1_1234_5678_0003;
  localparam logic [63:0] B2 = 64'hB2B2_1234_5678_0004, B3 = 64'hB3B3_1234_5678_0005;

  initial begin
    vec_t tbl [6];
    int first;
    logic [11:0] lo;

    // Reads carry the expected beats in d.
    tbl[0] = mk(1'b1, 21'h00040, D1, D2, D3, D4);
    tbl[1] = mk(1'b0, 21'h00040, D1, D2, D3, D4);
    tbl[2] = mk(1'b1, 21'h00FFE, A0, A1, A2, A3);
    tbl[3] = mk(1'b1, 21'h01002, B0, B1, B2, B3);
    tbl[4] = mk(1'b0, 21'h00FFE, A0, A1, A2, A3);
    tbl[5] = mk(1'b0, 21'h1F000, A2, A3, B0, B1);

    rst = 1; cmd = 0; cmd_en = 0; addr = '0; wr_data = '0; data_mask = 8'hFF;
    idle(2);
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    // Command during INIT is rejected; init_calib still rises after 10 edges.
    rst = 0; first = 0;
    for (int k = 1; k <= 20; k++) begin
      cmd_en = (k == 4); cmd = 1'b0;
      tick();
      if (init_calib && first == 0) first = k;
    end
    cmd_en = 0;
    chk("init_calib_edge", 64'(first), 64'd10);
    chk("init_reject_perr", 64'(protocol_error), 64'h1);

    foreach (tbl[i]) begin
      cmd_en = 1; cmd = tbl[i].wr; addr = tbl[i].a; wr_data = tbl[i].d[0];
      if (tbl[i].wr) begin
        tick(); cmd_en = 0;
        for (int k = 1; k < 4; k++) begin wr_data = tbl[i].d[k]; tick(); end
        idle(11);
      end else begin
        cap.delete();
        tick(); cmd_en = 0; wr_data = '0;
        wait_beats(4, "tbl_read_timeout");
        for (int k = 0; k < 4 && k < cap.size(); k++)
          chk($sformatf("tbl%0d_beat%0d", i, k), cap[k], tbl[i].d[k]);
        idle(6);
      end
    end

    // Command 5 edges into a read is rejected and the read completes intact.
    cap.delete();
    cmd_en = 1; cmd = 0; addr = 21'h00040; tick(); cmd_en = 0;
    idle(4);
    cmd_en = 1; cmd = 1; addr = 21'h00100; wr_data = 64'hDEAD; tick(); cmd_en = 0;
    wait_beats(4, "reject_read_timeout");
    if (cap.size() == 4) begin
      chk("reject_beat0", cap[0], D1);
      chk("reject_beat3", cap[3], D4);
    end
    chk("reject_perr", 64'(protocol_error), 64'h1);
    idle(6);

    // Reset while the second read beat is on the bus.
    cap.delete();
    cmd_en = 1; cmd = 0; addr = 21'h00040; tick(); cmd_en = 0;
    wait_beats(2, "rst_read_timeout");
    rst = 1; tick(); rst = 0;
    chk("rst_mid_vld", 64'(rd_data_valid), 64'h0);
    chk("rst_mid_calib", 64'(init_calib), 64'h0);
    chk("rst_mid_perr", 64'(protocol_error), 64'h0);
    idle(12);

    // Reset during a write: the two beats already taken stay in the array.
    cmd_en = 1; cmd = 1; addr = 21'h00040; wr_data = 64'hAAAA; tick(); cmd_en = 0;
    wr_data = 64'hBBBB; tick();
    wr_data = 64'hCCCC; rst = 1; tick(); rst = 0;
    idle(12);
    cap.delete();
    cmd_en = 1; cmd = 0; addr = 21'h00040; tick(); cmd_en = 0;
    wait_beats(4, "partial_read_timeout");
    if (cap.size() == 4) begin
      chk("partial_beat0", cap[0], 64'hAAAA);
      chk("partial_beat1", cap[1], 64'hBBBB);
      chk("partial_beat2", cap[2], D3);
      chk("partial_beat3", cap[3], D4);
    end
    idle(6);

    // Random traffic near the array ends, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      lo = ($urandom % 2 == 0) ? 12'($urandom % 16) : 12'(12'hFF8 + 12'($urandom % 8));
      addr = {9'($urandom), lo};
      cmd = 1'($urandom);
      cmd_en = ($urandom % 6 == 0);
      wr_data = {$urandom, $urandom};
      rst = ($urandom % 700 == 0);
      tick();
    end
    rst = 0; cmd_en = 0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
